ram_wb_arbiter: RTL and testbench
=================================

// Module: ram_wb_arbiter
// PURPOSE
//  Shares one single-port on-chip RAM between two Wishbone slave ports.
//  The RAM is byte-enabled, 4096x32, with a registered 1-cycle read.
//  m0 = instruction-fetch port, m1 = data port. Fair round-robin arbitration.
//  Sequences each RAM access and generates the Wishbone ack and read data.
//  Sits between the bus interconnect and the RAM inside the on-chip-RAM peripheral.
// PARAMETERS
//  ADDR_W  12  RAM word-address width; RAM index = mX_adr_i[ADDR_W+1:2]
// PORTS
//  clk_i      in   1       single clock, all logic on posedge
//  rst_i      in   1       reset, synchronous, active-high
//  mX_cyc_i   in   1       WB cycle, X in {0,1}
//  mX_stb_i   in   1       WB strobe
//  mX_we_i    in   1       WB write enable
//  mX_adr_i   in   32      WB byte address; bits [1:0] ignored
//  mX_sel_i   in   4       WB byte selects
//  mX_dat_i   in   32      WB write data
//  mX_dat_o   out  32      WB read data, valid only while mX_ack_o=1, else 0
//  mX_ack_o   out  1       WB ack, single-cycle pulse
//  ram_we_o   out  1       RAM write enable
//  ram_adr_o  out  ADDR_W  RAM word address
//  ram_be_o   out  4       RAM byte enables
//  ram_dat_o  out  32      RAM write data
//  ram_dat_i  in   32      RAM registered read data
// BEHAVIOUR
//  - Request: reqX = mX_cyc_i & mX_stb_i.
//  - FSM states:
//    - IDLE: if any reqX at a posedge, latch grant, we, adr, sel and dat into ram_* regs; go to ACCESS.
//    - ACCESS: ram_* outputs drive the RAM for exactly this cycle; the RAM samples at the end-of-cycle edge; go to RESP.
//    - RESP: ram_dat_i holds the RAM's output for the latched address; go to IDLE.
//  - Ack: in RESP, mG_ack_o = reqG (G = granted master), combinational.
//    - mG_dat_o = ram_dat_i when acking; otherwise 0.
//  - Latency: stb sampled at edge E0 -> ack high in the cycle after E1.
//    - Fixed 3-cycle occupancy per transfer, reads and writes alike.
//    - Write data in RAM from the cycle after ACCESS.
//  - ram_we_o = 1 only in ACCESS, and only for latched writes.
//    - ram_adr_o/be_o/dat_o hold their value outside ACCESS; don't-care to the RAM.
//  - Arbitration in IDLE:
//    - One requester: it wins.
//    - Both requesting: the master != last_grant wins.
//    - last_grant updates on every grant and resets to 1, so m0 wins the first tie.
//    - The loser keeps stb high and is served next (no starvation).
//  - The non-granted master never sees ack; its dat_o stays 0.
//  - Abort: if the granted master drops cyc/stb in ACCESS or RESP:
//    - the RAM access still completes (writes land);
//    - no ack is issued.
//  - A master holding stb after its ack is treated as a new request in IDLE; subject to round-robin.
//  - Reset (any state, including mid-transfer): next cycle has
//    - state=IDLE, last_grant=1, ram_we_o=0, ram_adr_o=0, ram_be_o=0, ram_dat_o=0;
//    - all acks 0, all mX_dat_o 0.
//    - An interrupted write's data is not applied if reset is sampled during IDLE->ACCESS.
//  - Never more than one ack per cycle. Never more than one RAM access in flight.
// STRUCTURE
//  - Package wbc_ram_pkg:
//    - ADDR_W default;
//    - typedef enum logic[1:0] {IDLE,ACCESS,RESP} ram_arb_state_t;
//    - typedef logic master_id_t;
//    - typedef struct {we, adr, sel, dat} wb_req_t.
//  - Sub-module rr_arbiter2:
//    - 2-requester round-robin;
//    - inputs req[1:0], last_grant, grant-enable;
//    - outputs grant id, valid.
//  - The top holds the FSM, the request latch and the ack/data mux.
// TESTING
//  1. Reset, then m0 reads 0x0000_0000 (RAM[0]=0x3C01A000)
//     -> m0_ack_o high 2 cycles after stb is sampled; m0_dat_o=0x3C01A000; m1_ack_o=0 throughout.
//  2. m1 writes 0xDEADBEEF to 0x10 with sel=4'b0101, then reads 0x10 (prior content 0)
//     -> read returns 0x00AD00EF.
//  3. m0 and m1 request simultaneously after reset; both hold stb until acked
//     -> order m0, m1, m0, m1 ...; one ack every 3 cycles.
//  4. m1 writes 0x12345678 to 0x20 and drops cyc in ACCESS
//     -> no m1 ack; a later m0 read of 0x20 returns 0x12345678.
//  5. rst_i asserted in ACCESS of an m0 write
//     -> next cycle: ram_we_o=0, state IDLE, acks 0; the following m0 read-back completes normally.
//  6. Address 0x3FFC (ADDR_W=12, last word) and 0x4000 aliasing
//     -> 0x4000 maps to word 0; m1 write there is visible at 0x0000.

Source files
------------

// File: rtl/wbc_ram_pkg.sv
// Shared types for the on-chip RAM Wishbone arbiter: FSM states, master id
// and the latched request record.
package wbc_ram_pkg;
  localparam int ADDR_W_DEF = 12;
  localparam int WORD_AW    = 30;  // full word address carried by the latch

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} ram_arb_state_t;

  typedef logic master_id_t;

  typedef struct packed {
    logic               we;
    logic [WORD_AW-1:0] adr;
    logic [3:0]         sel;
    logic [31:0]        dat;
  } wb_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin: on a tie the master that did not win last time
// is chosen; a lone requester always wins.
module rr_arbiter2
  import wbc_ram_pkg::*;
(
  input  logic [1:0] i_req,
  input  master_id_t i_last_grant,
  input  logic       i_en,
  output master_id_t o_grant,
  output logic       o_valid
);

  always_comb begin
    o_grant = 1'b0;
    if (&i_req)       o_grant = ~i_last_grant;
    else if (i_req[1]) o_grant = 1'b1;
  end

  assign o_valid = i_en & (|i_req);

endmodule

// File: rtl/ram_wb_arbiter.sv
// Shares one single-port 1-cycle-read RAM between two Wishbone slave ports:
// each transfer takes IDLE -> ACCESS -> RESP, ack is raised combinationally in RESP.
module ram_wb_arbiter
  import wbc_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [31:0]       m0_adr_i,
  input  logic [3:0]        m0_sel_i,
  input  logic [31:0]       m0_dat_i,
  output logic [31:0]       m0_dat_o,
  output logic              m0_ack_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [31:0]       m1_adr_i,
  input  logic [3:0]        m1_sel_i,
  input  logic [31:0]       m1_dat_i,
  output logic [31:0]       m1_dat_o,
  output logic              m1_ack_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_adr_o,
  output logic [3:0]        ram_be_o,
  output logic [31:0]       ram_dat_o,
  input  logic [31:0]       ram_dat_i
);

  ram_arb_state_t r_state, w_next;
  master_id_t     r_grant, r_last_grant, w_gnt;
  wb_req_t        r_req, w_sel_req;
  logic [1:0]     w_req;
  logic           w_gnt_vld, w_ack_en;

  assign w_req = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};

  rr_arbiter2 u_arb (
    .i_req       (w_req),
    .i_last_grant(r_last_grant),
    .i_en        (r_state == IDLE),
    .o_grant     (w_gnt),
    .o_valid     (w_gnt_vld)
  );

  always_comb begin
    w_sel_req = '{we: m0_we_i, adr: m0_adr_i[31:2], sel: m0_sel_i, dat: m0_dat_i};
    if (w_gnt)
      w_sel_req = '{we: m1_we_i, adr: m1_adr_i[31:2], sel: m1_sel_i, dat: m1_dat_i};
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_gnt_vld) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_req        <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_vld) begin
        r_grant      <= w_gnt;
        r_last_grant <= w_gnt;
        r_req        <= w_sel_req;
      end
    end
  end

  // The RAM is touched only in ACCESS; the address/data regs just hold otherwise.
  assign ram_we_o  = (r_state == ACCESS) & r_req.we;
  assign ram_adr_o = r_req.adr[ADDR_W-1:0];
  assign ram_be_o  = r_req.sel;
  assign ram_dat_o = r_req.dat;

  // A master that dropped its strobe mid-transfer gets no ack.
  assign w_ack_en = (r_state == RESP);
  assign m0_ack_o = w_ack_en & ~r_grant & w_req[0];
  assign m1_ack_o = w_ack_en &  r_grant & w_req[1];
  assign m0_dat_o = m0_ack_o ? ram_dat_i : 32'h0;
  assign m1_dat_o = m1_ack_o ? ram_dat_i : 32'h0;

  logic w_unused;
  assign w_unused = ^{m0_adr_i[1:0], m1_adr_i[1:0], r_req.adr[WORD_AW-1:ADDR_W]};

endmodule

// File: tb/tb_ram_wb_arbiter.sv
// Bench for ram_wb_arbiter: behavioural RAM, reference memory and per-master
// scoreboard queues of expected read data.
module tb_ram_wb_arbiter;
  import wbc_ram_pkg::*;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_i;
  logic m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [31:0] m0_adr, m0_dat_i, m0_dat_o, m1_adr, m1_dat_i, m1_dat_o;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_ack, m1_ack;
  logic        ram_we;
  logic [AW-1:0] ram_adr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdat, ram_rdat;

  always #5 clk = ~clk;

  ram_wb_arbiter #(.ADDR_W(AW)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack),
    .ram_we_o(ram_we), .ram_adr_o(ram_adr), .ram_be_o(ram_be), .ram_dat_o(ram_wdat),
    .ram_dat_i(ram_rdat)
  );

  // Behavioural RAM with registered read.
  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (ram_we && ram_be[b]) mem[ram_adr][8*b +: 8] <= ram_wdat[8*b +: 8];
    ram_rdat <= mem[ram_adr];
  end

  typedef struct { bit rd; logic [31:0] d; } exp_t;
  exp_t q0[$], q1[$];
  exp_t e;

  int n_chk = 0, n_err = 0;
  int cyc = 0, n_ack1 = 0;
  bit rr_on = 0, rr_have = 0;
  int rr_prev_cyc;
  logic rr_prev_m;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on every ack and checks bus invariants.
  always @(negedge clk) begin
    if (!rst_i) begin
      chk("one_ack", {31'b0, m0_ack & m1_ack}, 32'h0);
      if (!m0_ack) chk("m0_dat_idle", m0_dat_o, 32'h0);
      if (!m1_ack) chk("m1_dat_idle", m1_dat_o, 32'h0);
      if (m0_ack) begin
        if (q0.size() == 0) chk("m0_unexp_ack", 32'h1, 32'h0);
        else begin
          e = q0.pop_front();
          if (e.rd) chk("m0_rdata", m0_dat_o, e.d);
        end
      end
      if (m1_ack) begin
        n_ack1 <= n_ack1 + 1;
        if (q1.size() == 0) chk("m1_unexp_ack", 32'h1, 32'h0);
        else begin
          e = q1.pop_front();
          if (e.rd) chk("m1_rdata", m1_dat_o, e.d);
        end
      end
      if (rr_on && (m0_ack || m1_ack)) begin
        if (rr_have) begin
          chk("rr_gap", cyc - rr_prev_cyc, 32'd3);
          chk("rr_order", {31'b0, m1_ack}, {31'b0, ~rr_prev_m});
        end else
          chk("rr_first", {31'b0, m1_ack}, 32'h0);
        rr_have = 1;
        rr_prev_cyc = cyc;
        rr_prev_m = m1_ack;
      end
    end
  end

  function automatic int widx(input logic [31:0] adr);
    return int'(adr[AW+1:2]);
  endfunction

  task automatic drive(input int m, input logic on, input logic we, input logic [31:0] adr,
                       input logic [3:0] sel, input logic [31:0] dat);
    if (m == 0) begin
      m0_cyc = on; m0_stb = on; m0_we = we; m0_adr = adr; m0_sel = sel; m0_dat_i = dat;
    end else begin
      m1_cyc = on; m1_stb = on; m1_we = we; m1_adr = adr; m1_sel = sel; m1_dat_i = dat;
    end
  endtask

  // Full transfer: push expectation, hold the strobe until ack, release after the ack cycle.
  task automatic wb_xfer(input int m, input logic we, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] dat, output int lat);
    exp_t x;
    bit done = 0;
    int w = widx(adr);
    x.rd = !we;
    x.d  = ref_mem[w];
    if (we)
      for (int b = 0; b < 4; b++) if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
    if (m == 0) q0.push_back(x); else q1.push_back(x);
    drive(m, 1'b1, we, adr, sel, dat);
    lat = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); lat++;
      @(negedge clk);
      if ((m == 0) ? m0_ack : m1_ack) done = 1;
    end
    if (!done) chk("ack_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
    drive(m, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  int lat, lat1;

  initial begin
    for (int i = 0; i < 4096; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    mem[0] = 32'h3C01A000; ref_mem[0] = 32'h3C01A000;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    do_reset();

    // Reset state
    @(negedge clk);
    chk("rst_we", {31'b0, ram_we}, 32'h0);
    chk("rst_adr", 32'(ram_adr), 32'h0);
    chk("rst_be", 32'(ram_be), 32'h0);
    chk("rst_wdat", ram_wdat, 32'h0);
    chk("rst_last", {31'b0, dut.r_last_grant}, 32'h1);
    @(posedge clk); #1;

    // 1: m0 read of word 0, latency 2
    wb_xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, lat);
    chk("t1_lat", lat, 32'd2);

    // 2: m1 byte-masked write then read
    wb_xfer(1, 1'b1, 32'h10, 4'b0101, 32'hDEADBEEF, lat);
    wb_xfer(1, 1'b0, 32'h10, 4'hF, 32'h0, lat);
    chk("t2_ref", ref_mem[4], 32'h00AD00EF);

    // 3: round robin after reset, both masters back-to-back
    do_reset();
    rr_on = 1; rr_have = 0;
    fork
      begin for (int i = 0; i < 4; i++) wb_xfer(0, 1'b0, 32'h0, 4'hF, 32'h0, lat); end
      begin for (int j = 0; j < 4; j++) wb_xfer(1, 1'b0, 32'h10, 4'hF, 32'h0, lat1); end
    join
    rr_on = 0;
    repeat (2) @(posedge clk); #1;

    // 4: m1 write aborted in ACCESS still lands, no ack
    begin
      int a1;
      a1 = n_ack1;
      ref_mem[8] = 32'h12345678;
      drive(1, 1'b1, 1'b1, 32'h20, 4'hF, 32'h12345678);
      @(posedge clk); #1;
      drive(1, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      repeat (4) @(posedge clk); #1;
      chk("t4_noack", n_ack1, a1);
      wb_xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, lat);
    end

    // 5: reset during ACCESS of an m0 write; the RAM already saw the write strobe
    ref_mem[12] = 32'hCAFEF00D;
    drive(0, 1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
    @(posedge clk); #1;
    rst_i = 1'b1;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t5_acc_we", {31'b0, ram_we}, 32'h1);
    @(negedge clk);
    chk("t5_we", {31'b0, ram_we}, 32'h0);
    chk("t5_state", 32'(dut.r_state), 32'(IDLE));
    chk("t5_acks", {30'b0, m1_ack, m0_ack}, 32'h0);
    chk("t5_adr", 32'(ram_adr), 32'h0);
    @(posedge clk); #1 rst_i = 1'b0;
    wb_xfer(0, 1'b0, 32'h30, 4'hF, 32'h0, lat);
    chk("t5_lat", lat, 32'd2);

    // 5b: reset sampled on the IDLE->ACCESS edge drops the write
    drive(0, 1'b1, 1'b1, 32'h40, 4'hF, 32'h00000055);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    chk("t5b_we", {31'b0, ram_we}, 32'h0);
    @(posedge clk); #1;
    wb_xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, lat);

    // 6: last word and address aliasing
    wb_xfer(1, 1'b1, 32'h3FFC, 4'hF, 32'hA5A50001, lat);
    wb_xfer(0, 1'b0, 32'h3FFC, 4'hF, 32'h0, lat);
    wb_xfer(1, 1'b1, 32'h4000, 4'hF, 32'h11223344, lat);
    wb_xfer(0, 1'b0, 32'h0000, 4'hF, 32'h0, lat);
    chk("t6_alias_ref", ref_mem[0], 32'h11223344);

    repeat (3) @(posedge clk);
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
